// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: data-memory request controller between execute and the data memory port.
//
// Turns one LW/LBU/SW/SB from execute into a single memory transaction, stalls the
// pipeline until it completes and returns zero-extended load data.
//
// Ports:
//   clk          core clock
//   n_reset      asynchronous active-low reset
//   req_valid_i  execute holds a memory op until done_o
//   req_store_i  1 = SW/SB, 0 = LW/LBU
//   req_byte_i   1 = LBU/SB, 0 = LW/SW
//   req_addr_i   byte address
//   req_wdata_i  store data
//   stall_o      freeze pipeline
//   done_o       one-cycle completion pulse, rdata_o valid with it
//   rdata_o      load result (held until the next load completes)
//   mem_addr_o   address to data memory (word accesses forced word-aligned)
//   to_mem_o     mem_in_s  {write_data[31:0], valid, wen, byte_not_word, yumi}
//   from_mem_i   mem_out_s {read_data[31:0], valid, yumi}
//   err_o        sticky misalignment / unexpected-response / timeout error
//
// Optional: define DMEM_TIMEOUT_EN to enable a watchdog that abandons a request
// after TIMEOUT_CYCLES cycles. ADDR_W must be in 3..31.
module dmem_req_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              req_valid_i,
    input  logic              req_store_i,
    input  logic              req_byte_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [35:0]       to_mem_o,
    input  logic [33:0]       from_mem_i,
    output logic              err_o
);
    typedef enum logic [1:0] {DMEM_IDLE, DMEM_REQ_SENT, DMEM_REQ_ACKED} dmem_req_state_e;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;
    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    dmem_req_state_e   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic              store_q, store_d, byte_q, byte_d;
    logic              done_q, done_d, err_q, err_d;
    logic              accept, capture, store_done, acked, unexpected, misalign, timeout, busy;
    mem_in_s           mi;
    mem_out_s          mo;
    logic              unused_bits;

    assign mo          = from_mem_i;
    assign unused_bits = ^{req_addr_i[31:ADDR_W], TIMEOUT_CYCLES[0]};
    assign busy        = state_q != DMEM_IDLE;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of busy cycles already spent before the current one
    assign cnt_d   = accept ? '0 : busy ? cnt_q + CNT_W'(1) : cnt_q;
    assign timeout = busy && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && !capture && !store_done;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        // done_q blocks re-acceptance: execute still shows the op that just completed
        accept     = state_q == DMEM_IDLE && req_valid_i && !done_q;
        store_done = state_q == DMEM_REQ_SENT && store_q && mo.yumi;
        acked      = state_q == DMEM_REQ_SENT && !store_q && mo.yumi;
        capture    = mo.valid && (acked || state_q == DMEM_REQ_ACKED);
        unexpected = mo.valid && (state_q == DMEM_IDLE || (state_q == DMEM_REQ_SENT && store_q));
        misalign   = accept && !req_byte_i && |req_addr_i[1:0];
        done_d     = capture || store_done || timeout;
        state_d    = accept ? DMEM_REQ_SENT : done_d ? DMEM_IDLE : acked ? DMEM_REQ_ACKED : state_q;
        addr_d     = accept ? req_addr_i[ADDR_W-1:0] : addr_q;
        wdata_d    = accept ? req_wdata_i : wdata_q;
        store_d    = accept ? req_store_i : store_q;
        byte_d     = accept ? req_byte_i : byte_q;
        err_d      = err_q || misalign || unexpected || timeout;
        rdata_d    = timeout ? 32'h0 :
                     capture ? (byte_q ? {24'h0, mo.read_data[{addr_q[1:0], 3'b000} +: 8]} : mo.read_data) :
                     rdata_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= DMEM_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            byte_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            store_q <= store_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Responses are always drained except a load response that arrives before its ack;
    // gated by reset so every memory-side output is 0 while n_reset is low.
    always_comb begin
        mi.write_data    = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
        mi.valid         = state_q == DMEM_REQ_SENT;
        mi.wen           = store_q;
        mi.byte_not_word = byte_q;
        mi.yumi          = n_reset && mo.valid && (state_q != DMEM_REQ_SENT || store_q || mo.yumi);
    end

    assign to_mem_o   = mi;
    assign mem_addr_o = byte_q ? addr_q : {addr_q[ADDR_W-1:2], 2'b00};
    assign stall_o    = n_reset && (busy || (req_valid_i && !done_q));
    assign done_o     = done_q;
    assign rdata_o    = rdata_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl: table-driven cycle vectors plus reset and watchdog sequences.
module tb_dmem_req_ctrl;
    logic        clk = 1'b0;
    logic        n_reset;
    logic        rv, st, by, my, mv;
    logic [31:0] addr, wd, md;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic [11:0] maddr;
    logic [35:0] to_mem;
    logic [33:0] from_mem;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign from_mem = {md, mv, my};

    dmem_req_ctrl #(.ADDR_W(12), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .n_reset(n_reset), .req_valid_i(rv), .req_store_i(st), .req_byte_i(by),
        .req_addr_i(addr), .req_wdata_i(wd), .stall_o(stall), .done_o(done), .rdata_o(rdata),
        .mem_addr_o(maddr), .to_mem_o(to_mem), .from_mem_i(from_mem), .err_o(err)
    );

    typedef struct {
        logic        rv, st, by;
        logic [31:0] addr, wd;
        logic        my, mv;
        logic [31:0] md;
        logic        stall, done, tv, ty, wen, bnw, err;
        logic [11:0] maddr;
        logic [31:0] wdo, rdata;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic rv_, st_, by_, logic [31:0] a_, w_, logic my_, mv_, logic [31:0] md_,
                                logic s_, d_, tv_, ty_, we_, bn_, e_, logic [11:0] ma_, logic [31:0] wo_, rd_);
        vec_t v;
        v.rv = rv_; v.st = st_; v.by = by_; v.addr = a_; v.wd = w_; v.my = my_; v.mv = mv_; v.md = md_;
        v.stall = s_; v.done = d_; v.tv = tv_; v.ty = ty_; v.wen = we_; v.bnw = bn_; v.err = e_;
        v.maddr = ma_; v.wdo = wo_; v.rdata = rd_;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rv_, st_, by_, logic [31:0] a_, w_, logic my_, mv_, logic [31:0] md_);
        rv = rv_; st = st_; by = by_; addr = a_; wd = w_; my = my_; mv = mv_; md = md_;
    endtask

    initial begin
        int n;
        int ndone;
        // SW 0x010: done two cycles after request, stall exactly two cycles
        vecs[0]  = mk(1,1,0,32'h010,32'hCAFEBABE,0,0,0,          1,0,0,0,0,0,0,12'h000,0,0);
        vecs[1]  = mk(1,1,0,32'h010,32'hCAFEBABE,1,0,0,          1,0,1,0,1,0,0,12'h010,32'hCAFEBABE,0);
        vecs[2]  = mk(1,1,0,32'h010,32'hCAFEBABE,0,0,0,          0,1,0,0,0,0,0,12'h000,0,0);
        vecs[3]  = mk(0,0,0,0,0,0,0,0,                           0,0,0,0,0,0,0,12'h000,0,0);
        // LW 0x020: ack, then three REQ_ACKED cycles, data on the third
        vecs[4]  = mk(1,0,0,32'h020,0,0,0,0,                     1,0,0,0,0,0,0,12'h000,0,0);
        vecs[5]  = mk(1,0,0,32'h020,0,1,0,0,                     1,0,1,0,0,0,0,12'h020,0,0);
        vecs[6]  = mk(1,0,0,32'h020,0,0,0,0,                     1,0,0,0,0,0,0,12'h000,0,0);
        vecs[7]  = mk(1,0,0,32'h020,0,0,0,0,                     1,0,0,0,0,0,0,12'h000,0,0);
        vecs[8]  = mk(1,0,0,32'h020,0,0,1,32'h12345678,          1,0,0,1,0,0,0,12'h000,0,0);
        vecs[9]  = mk(1,0,0,32'h020,0,0,0,0,                     0,1,0,0,0,0,0,12'h000,0,32'h12345678);
        vecs[10] = mk(0,0,0,0,0,0,0,0,                           0,0,0,0,0,0,0,12'h000,0,32'h12345678);
        // LBU 0x033 with ack and data together: lane 3
        vecs[11] = mk(1,0,1,32'h033,0,0,0,0,                     1,0,0,0,0,0,0,12'h000,0,32'h12345678);
        vecs[12] = mk(1,0,1,32'h033,0,1,1,32'hAABBCCDD,          1,0,1,1,0,1,0,12'h033,0,32'h12345678);
        vecs[13] = mk(1,0,1,32'h033,0,0,0,0,                     0,1,0,0,0,0,0,12'h000,0,32'h000000AA);
        // SB 0x041 back-to-back after the done cycle: low byte replicated
        vecs[14] = mk(1,1,1,32'h041,32'hFFFFFF5A,0,0,0,          1,0,0,0,0,0,0,12'h000,0,32'h000000AA);
        vecs[15] = mk(1,1,1,32'h041,32'hFFFFFF5A,1,0,0,          1,0,1,0,1,1,0,12'h041,32'h5A5A5A5A,32'h000000AA);
        vecs[16] = mk(1,1,1,32'h041,32'hFFFFFF5A,0,0,0,          0,1,0,0,0,0,0,12'h000,0,32'h000000AA);
        vecs[17] = mk(0,0,0,0,0,0,0,0,                           0,0,0,0,0,0,0,12'h000,0,32'h000000AA);
        // misaligned LW 0x022: error, aligned address, still completes; then stray valid in IDLE
        vecs[18] = mk(1,0,0,32'h022,0,0,0,0,                     1,0,0,0,0,0,0,12'h000,0,32'h000000AA);
        vecs[19] = mk(1,0,0,32'h022,0,1,1,32'h0BADF00D,          1,0,1,1,0,0,1,12'h020,0,32'h000000AA);
        vecs[20] = mk(1,0,0,32'h022,0,0,0,0,                     0,1,0,0,0,0,1,12'h000,0,32'h0BADF00D);
        vecs[21] = mk(0,0,0,0,0,0,1,32'hDEADBEEF,                0,0,0,1,0,0,1,12'h000,0,32'h0BADF00D);
        vecs[22] = mk(0,0,0,0,0,0,0,0,                           0,0,0,0,0,0,1,12'h000,0,32'h0BADF00D);

        n_reset = 1'b0;
        drive(0,0,0,0,0,0,0,0);
        #1;
        chk("reset stall", {31'h0, stall}, 0);
        chk("reset done", {31'h0, done}, 0);
        chk("reset err", {31'h0, err}, 0);
        chk("reset rdata", rdata, 0);
        chk("reset to_mem", to_mem[35:4] | {28'h0, to_mem[3:0]}, 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rv, vecs[i].st, vecs[i].by, vecs[i].addr, vecs[i].wd, vecs[i].my, vecs[i].mv, vecs[i].md);
            @(negedge clk);
            chk($sformatf("v%0d stall", i), {31'h0, stall}, {31'h0, vecs[i].stall});
            chk($sformatf("v%0d done", i), {31'h0, done}, {31'h0, vecs[i].done});
            chk($sformatf("v%0d valid", i), {31'h0, to_mem[3]}, {31'h0, vecs[i].tv});
            chk($sformatf("v%0d yumi", i), {31'h0, to_mem[0]}, {31'h0, vecs[i].ty});
            chk($sformatf("v%0d err", i), {31'h0, err}, {31'h0, vecs[i].err});
            chk($sformatf("v%0d rdata", i), rdata, vecs[i].rdata);
            if (vecs[i].tv) begin
                chk($sformatf("v%0d wen", i), {31'h0, to_mem[2]}, {31'h0, vecs[i].wen});
                chk($sformatf("v%0d byte_not_word", i), {31'h0, to_mem[1]}, {31'h0, vecs[i].bnw});
                chk($sformatf("v%0d mem_addr", i), {20'h0, maddr}, {20'h0, vecs[i].maddr});
                chk($sformatf("v%0d write_data", i), to_mem[35:4], vecs[i].wdo);
            end
        end

        // reset while in REQ_ACKED: everything clears at once, next store completes normally
        @(posedge clk); #1 drive(1,0,0,32'h100,0,0,0,0);
        @(posedge clk); #1 drive(1,0,0,32'h100,0,1,0,0);
        @(posedge clk); #1 drive(1,0,0,32'h100,0,0,0,0);
        @(negedge clk);
        chk("acked stall", {31'h0, stall}, 1);
        chk("acked valid", {31'h0, to_mem[3]}, 0);
        #2 n_reset = 1'b0;
        #1;
        chk("async rst stall", {31'h0, stall}, 0);
        chk("async rst err", {31'h0, err}, 0);
        chk("async rst rdata", rdata, 0);
        chk("async rst mem_addr", {20'h0, maddr}, 0);
        chk("async rst to_mem", to_mem[35:4] | {28'h0, to_mem[3:0]}, 0);
        drive(0,0,0,0,0,0,0,0);
        @(negedge clk) n_reset = 1'b1;
        @(posedge clk); #1 drive(1,1,0,32'h0AC,32'h11223344,0,0,0);
        @(negedge clk) chk("post-rst stall", {31'h0, stall}, 1);
        @(posedge clk); #1 drive(1,1,0,32'h0AC,32'h11223344,1,0,0);
        @(negedge clk);
        chk("post-rst valid", {31'h0, to_mem[3]}, 1);
        chk("post-rst mem_addr", {20'h0, maddr}, 32'h0AC);
        chk("post-rst write_data", to_mem[35:4], 32'h11223344);
        @(posedge clk); #1 drive(1,1,0,32'h0AC,32'h11223344,0,0,0);
        @(negedge clk);
        chk("post-rst done", {31'h0, done}, 1);
        chk("post-rst err", {31'h0, err}, 0);
        @(posedge clk); #1 drive(0,0,0,0,0,0,0,0);

        // memory never acknowledges
        @(posedge clk); #1 drive(1,0,0,32'h200,0,0,0,0);
        n = 0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            n++;
            if (done) begin
                ndone++;
                break;
            end
        end
`ifdef DMEM_TIMEOUT_EN
        chk("timeout done seen", ndone, 1);
        chk("timeout latency", n, 10);
        chk("timeout rdata", rdata, 0);
        chk("timeout err", {31'h0, err}, 1);
        chk("timeout stall", {31'h0, stall}, 0);
        @(posedge clk); #1 drive(0,0,0,0,0,0,1,32'h77);
        @(negedge clk) chk("late resp yumi", {31'h0, to_mem[0]}, 1);
        @(posedge clk); #1 drive(0,0,0,0,0,0,0,0);
`else
        chk("no timeout done", ndone, 0);
        chk("no timeout stall", {31'h0, stall}, 1);
        chk("no timeout err", {31'h0, err}, 0);
        @(posedge clk); #1 drive(1,0,0,32'h200,0,1,1,32'h55);
        @(posedge clk); #1 drive(1,0,0,32'h200,0,0,0,0);
        @(negedge clk);
        chk("late ack done", {31'h0, done}, 1);
        chk("late ack rdata", rdata, 32'h55);
        @(posedge clk); #1 drive(0,0,0,0,0,0,0,0);
`endif
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
